// File: rtl/multicycle_ctrl.sv
// Control sequencer for the multicycle datapath: FETCH/DECODE/EXEC/MEM/WB with wait-state timeout.
// Latency: ALU op 4 cycles, load 5, store 4, branch 3 (+1 per memory wait cycle); strobes are combinational from state.
// Backpressure: memReady stalls FETCH/MEM; TIMEOUT consecutive stalls escalate to the sticky FAULT state.
//
// Ports:
//   CLK, RST_N           clock (rising edge) and synchronous active-low reset
//   op, cmpRst, memReady opcode, compare result ([0]=eq, [1]=lt), memory handshake
//   IRWrite..memAddrSel  1-bit datapath strobes; numBits/immShift/ALUOp/regDataWrite multi-bit selects
//   state, halted, fault current state encoding and sticky status
//   instRetired          retired-instruction counter, wraps modulo 2^CNT_W
module multicycle_ctrl #(
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [OP_W-1:0]  op,
  input  logic [1:0]       cmpRst,
  input  logic             memReady,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             writeEnable,
  output logic             DOrS,
  output logic             memEnableWrite,
  output logic             memEnableRead,
  output logic             PCWriteEnable,
  output logic             PCSource,
  output logic             loadInst,
  output logic             memAddrSel,
  output logic [1:0]       numBits,
  output logic [1:0]       immShift,
  output logic [2:0]       ALUOp,
  output logic [2:0]       regDataWrite,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instRetired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  // Counter must be able to hold TIMEOUT itself after the final increment.
  localparam int               WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   inst_retired_q, inst_retired_d;
  logic               retire;

  logic [3:0]         op_lo;
  logic               op_hi_set;
  logic               is_load;
  logic               unused_cmp_lt;

  assign op_lo         = op[3:0];
  assign op_hi_set     = (op >> 4) != '0;
  assign is_load       = (op_lo == 4'h9);
  // Only equality is needed for beq; less-than is reserved for future branch types.
  assign unused_cmp_lt = cmpRst[1];

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    retire         = 1'b0;
    IRWrite        = 1'b0;
    ALUSrcA        = 1'b0;
    ALUSrcB        = 1'b0;
    writeEnable    = 1'b0;
    DOrS           = 1'b0;
    memEnableWrite = 1'b0;
    memEnableRead  = 1'b0;
    PCWriteEnable  = 1'b0;
    PCSource       = 1'b0;
    loadInst       = 1'b0;
    memAddrSel     = 1'b0;
    numBits        = 2'b00;
    immShift       = 2'b00;
    ALUOp          = 3'b000;
    regDataWrite   = 3'b000;

    case (state_q)
      S_FETCH: begin
        memEnableRead = 1'b1;
        IRWrite       = 1'b1;
        // memReady wins over the timeout in the same cycle.
        if (memReady) begin
          state_d = S_DECODE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_LAST) state_d = S_FAULT;
        end
      end

      S_DECODE: begin
        immShift      = 2'b01;
        ALUSrcB       = 1'b1;
        numBits       = 2'b11;
        PCWriteEnable = 1'b1;
        if (op_hi_set || (op_lo >= 4'hC && op_lo <= 4'hE)) state_d = S_FAULT;
        else if (op_lo == 4'hF)                            state_d = S_HALT;
        else                                               state_d = S_EXEC;
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (op_lo <= 4'h7) begin
          ALUOp   = op_lo[2:0];
          state_d = S_WB;
        end else if (op_lo == 4'h8) begin
          ALUSrcB = 1'b1;
          state_d = S_WB;
        end else if (op_lo == 4'h9 || op_lo == 4'hA) begin
          ALUSrcB = 1'b1;
          state_d = S_MEM;
        end else if (op_lo == 4'hB) begin
          ALUOp = 3'b001;
          if (cmpRst[0]) begin
            PCWriteEnable = 1'b1;
            PCSource      = 1'b1;
          end
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          // Unreachable with a stable op; fail safe rather than guess.
          state_d = S_FAULT;
        end
      end

      S_MEM: begin
        memAddrSel     = 1'b1;
        memEnableRead  = is_load;
        memEnableWrite = ~is_load;
        if (memReady) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_LAST) state_d = S_FAULT;
        end
      end

      S_WB: begin
        writeEnable = 1'b1;
        if (is_load) begin
          regDataWrite = 3'b001;
          loadInst     = 1'b1;
        end
        state_d = S_FETCH;
        retire  = 1'b1;
      end

      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // Every fresh memory request starts its own wait budget.
    if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) wait_d = '0;

    // Datapath must see idle strobes while reset is held, whatever the stale state.
    if (!RST_N) begin
      IRWrite        = 1'b0;
      ALUSrcA        = 1'b0;
      ALUSrcB        = 1'b0;
      writeEnable    = 1'b0;
      DOrS           = 1'b0;
      memEnableWrite = 1'b0;
      memEnableRead  = 1'b0;
      PCWriteEnable  = 1'b0;
      PCSource       = 1'b0;
      loadInst       = 1'b0;
      memAddrSel     = 1'b0;
      numBits        = 2'b00;
      immShift       = 2'b00;
      ALUOp          = 3'b000;
      regDataWrite   = 3'b000;
    end
  end

  assign inst_retired_d = retire ? inst_retired_q + CNT_W'(1) : inst_retired_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q        <= S_FETCH;
      wait_q         <= '0;
      inst_retired_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      inst_retired_q <= inst_retired_d;
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);
  assign instRetired = inst_retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl (TIMEOUT=4, CNT_W=2).
// Stimulus pushes one expected record per cycle; the monitor pops and compares at negedge.
// Strobe vector order: IRWrite,ALUSrcA,ALUSrcB,writeEnable,DOrS,memEnableWrite,memEnableRead,
//                      PCWriteEnable,PCSource,loadInst,memAddrSel,numBits,immShift,ALUOp,regDataWrite
module tb_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] op = 4'h0;
  logic [1:0] cmpRst = 2'b00;
  logic       memReady = 1'b1;
  logic IRWrite, ALUSrcA, ALUSrcB, writeEnable, DOrS, memEnableWrite, memEnableRead;
  logic PCWriteEnable, PCSource, loadInst, memAddrSel;
  logic [1:0] numBits, immShift;
  logic [2:0] ALUOp, regDataWrite, state;
  logic       halted, fault;
  logic [1:0] instRetired;

  multicycle_ctrl #(.OP_W(4), .TIMEOUT(4), .CNT_W(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .op(op), .cmpRst(cmpRst), .memReady(memReady),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .writeEnable(writeEnable),
    .DOrS(DOrS), .memEnableWrite(memEnableWrite), .memEnableRead(memEnableRead),
    .PCWriteEnable(PCWriteEnable), .PCSource(PCSource), .loadInst(loadInst),
    .memAddrSel(memAddrSel), .numBits(numBits), .immShift(immShift), .ALUOp(ALUOp),
    .regDataWrite(regDataWrite), .state(state), .halted(halted), .fault(fault),
    .instRetired(instRetired)
  );

  always #5 CLK = ~CLK;

  localparam logic [20:0] V_ZERO   = 21'd0;
  localparam logic [20:0] V_FETCH  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,3'b000};
  localparam logic [20:0] V_DEC    = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b11,2'b01,3'b000,3'b000};
  localparam logic [20:0] V_EXIMM  = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,3'b000};
  localparam logic [20:0] V_EXBT   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,3'b001,3'b000};
  localparam logic [20:0] V_EXBN   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b001,3'b000};
  localparam logic [20:0] V_MEMLD  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b000,3'b000};
  localparam logic [20:0] V_MEMST  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b000,3'b000};
  localparam logic [20:0] V_WBALU  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,3'b000};
  localparam logic [20:0] V_WBLD   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,3'b001};

  // Register-register EXEC vector: ALUSrcA=1, ALUOp given.
  function automatic logic [20:0] ex_rr(input logic [2:0] a);
    return {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,a,3'b000};
  endfunction

  typedef struct {
    int          id;
    logic [2:0]  st;
    logic [20:0] strb;
    logic [1:0]  cnt;
    logic        h;
    logic        f;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   sid = 0;
  int   mon_cycles = 0;
  logic stim_done = 1'b0;
  logic [20:0] act_strb;

  assign act_strb = {IRWrite, ALUSrcA, ALUSrcB, writeEnable, DOrS, memEnableWrite, memEnableRead,
                     PCWriteEnable, PCSource, loadInst, memAddrSel, numBits, immShift, ALUOp, regDataWrite};

  // Drive one cycle of inputs right after the edge and record what that cycle must show.
  task automatic step(input logic [3:0] o, input logic [1:0] c, input logic mr, input logic rs,
                      input logic [2:0] st, input logic [20:0] sb, input logic [1:0] cn,
                      input logic h, input logic f);
    exp_t x;
    @(posedge CLK);
    #1;
    op = o; cmpRst = c; memReady = mr; RST_N = rs;
    sid++;
    x.id = sid; x.st = st; x.strb = sb; x.cnt = cn; x.h = h; x.f = f;
    exp_q.push_back(x);
  endtask

  // Four-cycle ALU instruction with memReady high; counter value shown is cn throughout.
  task automatic run_alu(input logic [3:0] o, input logic [20:0] ex, input logic [1:0] cn);
    step(o, 2'b00, 1'b1, 1'b1, 3'd0, V_FETCH, cn, 1'b0, 1'b0);
    step(o, 2'b00, 1'b1, 1'b1, 3'd1, V_DEC,   cn, 1'b0, 1'b0);
    step(o, 2'b00, 1'b1, 1'b1, 3'd2, ex,      cn, 1'b0, 1'b0);
    step(o, 2'b00, 1'b1, 1'b1, 3'd4, V_WBALU, cn, 1'b0, 1'b0);
  endtask

  always @(negedge CLK) begin
    mon_cycles++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state step %0d: got %0d expected %0d", e.id, state, e.st);
      end
      checks++;
      if (act_strb !== e.strb) begin
        errors++;
        $display("FAIL strobes step %0d: got %b expected %b", e.id, act_strb, e.strb);
      end
      checks++;
      if ({instRetired, halted, fault} !== {e.cnt, e.h, e.f}) begin
        errors++;
        $display("FAIL status step %0d: got cnt=%0d halted=%b fault=%b expected cnt=%0d halted=%b fault=%b",
                 e.id, instRetired, halted, fault, e.cnt, e.h, e.f);
      end
    end else if (stim_done) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
    if (mon_cycles > 2000) begin
      errors++;
      $display("FAIL watchdog: got %0d cycles expected at most 2000", mon_cycles);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    // Reset held: FETCH, everything idle.
    step(4'h0, 2'b00, 1'b1, 1'b0, 3'd0, V_ZERO, 2'd0, 1'b0, 1'b0);
    // ALU op 0x2.
    run_alu(4'h2, ex_rr(3'b010), 2'd1 - 2'd1);
    // Load with three MEM wait cycles: 8 cycles total.
    step(4'h9, 2'b00, 1'b1, 1'b1, 3'd0, V_FETCH, 2'd1, 1'b0, 1'b0);
    step(4'h9, 2'b00, 1'b1, 1'b1, 3'd1, V_DEC,   2'd1, 1'b0, 1'b0);
    step(4'h9, 2'b00, 1'b0, 1'b1, 3'd2, V_EXIMM, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'h9, 2'b00, 1'b0, 1'b1, 3'd3, V_MEMLD, 2'd1, 1'b0, 1'b0);
    step(4'h9, 2'b00, 1'b1, 1'b1, 3'd3, V_MEMLD, 2'd1, 1'b0, 1'b0);
    step(4'h9, 2'b00, 1'b1, 1'b1, 3'd4, V_WBLD,  2'd1, 1'b0, 1'b0);
    // Store.
    step(4'hA, 2'b00, 1'b1, 1'b1, 3'd0, V_FETCH, 2'd2, 1'b0, 1'b0);
    step(4'hA, 2'b00, 1'b1, 1'b1, 3'd1, V_DEC,   2'd2, 1'b0, 1'b0);
    step(4'hA, 2'b00, 1'b1, 1'b1, 3'd2, V_EXIMM, 2'd2, 1'b0, 1'b0);
    step(4'hA, 2'b00, 1'b1, 1'b1, 3'd3, V_MEMST, 2'd2, 1'b0, 1'b0);
    // beq taken, then not taken (counter wraps 3 -> 0 -> 1).
    step(4'hB, 2'b01, 1'b1, 1'b1, 3'd0, V_FETCH, 2'd3, 1'b0, 1'b0);
    step(4'hB, 2'b01, 1'b1, 1'b1, 3'd1, V_DEC,   2'd3, 1'b0, 1'b0);
    step(4'hB, 2'b01, 1'b1, 1'b1, 3'd2, V_EXBT,  2'd3, 1'b0, 1'b0);
    step(4'hB, 2'b10, 1'b1, 1'b1, 3'd0, V_FETCH, 2'd0, 1'b0, 1'b0);
    step(4'hB, 2'b10, 1'b1, 1'b1, 3'd1, V_DEC,   2'd0, 1'b0, 1'b0);
    step(4'hB, 2'b10, 1'b1, 1'b1, 3'd2, V_EXBN,  2'd0, 1'b0, 1'b0);
    // ALU immediate.
    run_alu(4'h8, V_EXIMM, 2'd1);
    // FETCH waits three cycles, memReady on the 4th (TIMEOUT) cycle rescues it.
    for (int i = 0; i < 3; i++) step(4'h7, 2'b00, 1'b0, 1'b1, 3'd0, V_FETCH, 2'd2, 1'b0, 1'b0);
    step(4'h7, 2'b00, 1'b1, 1'b1, 3'd0, V_FETCH,        2'd2, 1'b0, 1'b0);
    step(4'h7, 2'b00, 1'b1, 1'b1, 3'd1, V_DEC,          2'd2, 1'b0, 1'b0);
    step(4'h7, 2'b00, 1'b1, 1'b1, 3'd2, ex_rr(3'b111),  2'd2, 1'b0, 1'b0);
    step(4'h7, 2'b00, 1'b1, 1'b1, 3'd4, V_WBALU,        2'd2, 1'b0, 1'b0);
    // Load whose MEM never completes: FAULT after 4 MEM cycles, sticky, then reset.
    step(4'h9, 2'b00, 1'b1, 1'b1, 3'd0, V_FETCH, 2'd3, 1'b0, 1'b0);
    step(4'h9, 2'b00, 1'b1, 1'b1, 3'd1, V_DEC,   2'd3, 1'b0, 1'b0);
    step(4'h9, 2'b00, 1'b0, 1'b1, 3'd2, V_EXIMM, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(4'h9, 2'b00, 1'b0, 1'b1, 3'd3, V_MEMLD, 2'd3, 1'b0, 1'b0);
    step(4'h9, 2'b00, 1'b1, 1'b1, 3'd6, V_ZERO, 2'd3, 1'b0, 1'b1);
    step(4'h9, 2'b00, 1'b1, 1'b1, 3'd6, V_ZERO, 2'd3, 1'b0, 1'b1);
    step(4'h0, 2'b00, 1'b0, 1'b0, 3'd6, V_ZERO, 2'd3, 1'b0, 1'b1);
    // FETCH never ready: FAULT after exactly 4 cycles, counter cleared by the reset.
    for (int i = 0; i < 4; i++) step(4'h0, 2'b00, 1'b0, 1'b1, 3'd0, V_FETCH, 2'd0, 1'b0, 1'b0);
    step(4'h0, 2'b00, 1'b1, 1'b1, 3'd6, V_ZERO, 2'd0, 1'b0, 1'b1);
    step(4'h0, 2'b00, 1'b1, 1'b1, 3'd6, V_ZERO, 2'd0, 1'b0, 1'b1);
    step(4'h0, 2'b00, 1'b1, 1'b0, 3'd6, V_ZERO, 2'd0, 1'b0, 1'b1);
    // Illegal opcode 0xD.
    step(4'hD, 2'b00, 1'b1, 1'b1, 3'd0, V_FETCH, 2'd0, 1'b0, 1'b0);
    step(4'hD, 2'b00, 1'b1, 1'b1, 3'd1, V_DEC,   2'd0, 1'b0, 1'b0);
    step(4'hD, 2'b00, 1'b1, 1'b1, 3'd6, V_ZERO,  2'd0, 1'b0, 1'b1);
    step(4'h0, 2'b00, 1'b1, 1'b0, 3'd6, V_ZERO,  2'd0, 1'b0, 1'b1);
    // One ALU op, then HALT leaves the counter at 1.
    run_alu(4'h4, ex_rr(3'b100), 2'd0);
    step(4'hF, 2'b00, 1'b1, 1'b1, 3'd0, V_FETCH, 2'd1, 1'b0, 1'b0);
    step(4'hF, 2'b00, 1'b1, 1'b1, 3'd1, V_DEC,   2'd1, 1'b0, 1'b0);
    step(4'hF, 2'b00, 1'b1, 1'b1, 3'd5, V_ZERO,  2'd1, 1'b1, 1'b0);
    step(4'h2, 2'b00, 1'b1, 1'b1, 3'd5, V_ZERO,  2'd1, 1'b1, 1'b0);
    step(4'h0, 2'b00, 1'b1, 1'b0, 3'd5, V_ZERO,  2'd1, 1'b1, 1'b0);
    // Five back-to-back ALU ops: counter 1,2,3,0,1.
    run_alu(4'h0, ex_rr(3'b000), 2'd0);
    run_alu(4'h1, ex_rr(3'b001), 2'd1);
    run_alu(4'h3, ex_rr(3'b011), 2'd2);
    run_alu(4'h5, ex_rr(3'b101), 2'd3);
    run_alu(4'h6, ex_rr(3'b110), 2'd0);
    // Reset asserted mid-instruction (in EXEC): strobes forced idle, then clean FETCH.
    step(4'h2, 2'b00, 1'b1, 1'b1, 3'd0, V_FETCH, 2'd1, 1'b0, 1'b0);
    step(4'h2, 2'b00, 1'b1, 1'b1, 3'd1, V_DEC,   2'd1, 1'b0, 1'b0);
    step(4'h2, 2'b00, 1'b1, 1'b0, 3'd2, V_ZERO,  2'd1, 1'b0, 1'b0);
    step(4'h2, 2'b00, 1'b1, 1'b1, 3'd0, V_FETCH, 2'd0, 1'b0, 1'b0);
    stim_done = 1'b1;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised control sequencer for the multicycle datapath: it drives every datapath control strobe (IRWrite, ALU selects, register-file and memory enables, PC update) from the decoded opcode and compare result, so benches no longer hand-sequence them. It adds what hand-driven control lacks: per-opcode-class sequencing, memory wait states with timeout, branch resolution, halt/illegal-opcode handling and a retired-instruction counter. It connects directly to the datapath's control, `op` and `cmpRst` pins.

## Interface
- OP_W, 4: opcode width; opcodes with any bit above [3] set are illegal.
- TIMEOUT, 16: maximum consecutive memory-wait cycles before FAULT (≥1).
- CNT_W, 16: retired-instruction counter width.
- CLK  in  1  clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- op  in  OP_W  opcode from instruction register.
- cmpRst  in  2  [0]=equal, [1]=less-than.
- memReady  in  1  memory access completes this cycle.
- IRWrite, ALUSrcA, ALUSrcB, writeEnable, DOrS, memEnableWrite, memEnableRead, PCWriteEnable, PCSource, loadInst, memAddrSel  out  1 each  datapath strobes.
- numBits  out  2;  immShift  out  2;  ALUOp  out  3;  regDataWrite  out  3.
- state  out  3  current state encoding.
- halted  out  1;  fault  out  1;  instRetired  out  CNT_W.

## Operation
- States (encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6.
- Outputs are decoded from state (and op in EXEC/MEM/WB). Any strobe not listed below is 0.
- FETCH: memAddrSel=0, memEnableRead=1, IRWrite=1. Stay until memReady=1, then go to DECODE.
- DECODE: immShift=01, ALUOp=000, ALUSrcA=0, ALUSrcB=1, numBits=11, PCWriteEnable=1, PCSource=0. Next state: HALT if op=0xF; FAULT if op is illegal (0xC–0xE or upper bits set); otherwise EXEC.
- EXEC:
  - op 0x0–0x7 (ALU reg-reg): ALUOp=op[2:0], ALUSrcA=1, ALUSrcB=0, DOrS=0; go to WB.
  - op 0x8 (ALU imm): ALUOp=000, ALUSrcA=1, ALUSrcB=1, immShift=00, DOrS=0; go to WB.
  - op 0x9/0xA (load/store address): ALUOp=000, ALUSrcA=1, ALUSrcB=1; go to MEM.
  - op 0xB (beq): ALUOp=001, ALUSrcA=1, ALUSrcB=0. If cmpRst[0]=1, assert PCWriteEnable=1 and PCSource=1. Go to FETCH and retire.
- MEM: memAddrSel=1; memEnableRead=1 for load, memEnableWrite=1 for store. Stay until memReady=1. A load then goes to WB; a store goes to FETCH and retires.
- WB: writeEnable=1; regDataWrite=000 for ALU ops, 001 with loadInst=1 for load. Go to FETCH and retire.
- Wait counter: cleared on entry to FETCH and MEM; increments each cycle memReady=0. When it reaches TIMEOUT with memReady still 0, go to FAULT. memReady=1 in the same cycle takes priority over timeout.
- HALT: halted=1, all strobes 0. FAULT: fault=1, all strobes 0. Both are sticky until reset.
- instRetired increments by 1 on each retire event and wraps modulo 2^CNT_W. HALT does not count as a retire.

## Timing
- Reset (RST_N=0 at a rising edge): state=FETCH, instRetired=0, wait counter=0, halted=0, fault=0. Reset overrides everything, including mid-instruction and in HALT/FAULT.
- Strobes are combinational from the registered state, so they are valid throughout the cycle. While RST_N=0 all strobes are held at 0; FETCH strobes assert from the first cycle with RST_N=1.
- op must be stable from DECODE until the instruction leaves EXEC/MEM/WB.
- Latency with memReady=1 on first request: ALU op 4 cycles, load 5, store 4, branch 3.
- Each wait cycle extends FETCH/MEM by 1. With memReady never asserted, FAULT is entered TIMEOUT cycles after state entry.

## Test plan
- ALU op 0x2, memReady tied 1 → states 0,1,2,4,0; ALUOp=010 in EXEC; writeEnable=1 only in WB; instRetired=1.
- Load 0x9, memReady low 3 cycles in MEM → MEM held 4 cycles with memAddrSel=1 and memEnableRead=1; WB has regDataWrite=001 and loadInst=1; total 8 cycles.
- beq 0xB with cmpRst=01 → PCWriteEnable=1 and PCSource=1 in EXEC. With cmpRst=10 → PCSource=0 and PCWriteEnable=0. Both retire after 3 cycles.
- memReady held 0 in FETCH with TIMEOUT=4 → FAULT after 4 cycles, fault=1, strobes 0. Asserting memReady on the 4th cycle instead → DECODE.
- op=0xF → HALT after DECODE with halted=1, counter unchanged. op=0xD → FAULT. RST_N pulse low → state=0 and counter=0.
- CNT_W=2: 5 ALU ops back to back → instRetired sequence 1,2,3,0,1.
